mesh_port_arbiter: RTL and testbench
====================================

// Module: mesh_port_arbiter
// PURPOSE
//  Round-robin arbiter for one mesh-router output link. Shares the link among NUM_REQ
//  input FIFOs (pndng/pop, first-word-fall-through) and holds one granted packet in an
//  output register until the downstream terminal consumes it with popin.
//  Sits between the router's per-direction input FIFOs and each output port.
// PARAMETERS
//  NUM_REQ   4          number of requesting input FIFOs (>=2)
//  pckg_sz   40         packet width in bits
//  ID_W      8          width of destination-id field, packet bits [pckg_sz-1 -: ID_W]
//  bdcst     {8{1'b1}}  destination id that marks a broadcast packet (ID_W bits)
//  CNT_W     16         width of delivered-packet counter
// PORTS
//  clk        in   1                 clock, rising edge
//  reset      in   1                 asynchronous, active-low reset
//  pndng_i    in   NUM_REQ           FIFO r has a packet at its head
//  data_i     in   NUM_REQ*pckg_sz   head packets, r at [r*pckg_sz +: pckg_sz]
//  pop_o      out  NUM_REQ           one-hot pop to the granted FIFO
//  data_out   out  pckg_sz           held packet
//  pndng_out  out  1                 data_out valid, waiting for popin
//  popin      in   1                 downstream consumes data_out this cycle
//  grant_o    out  NUM_REQ           one-hot owner of the held packet (0 when empty)
//  pkt_cnt    out  CNT_W             packets consumed since reset
// BEHAVIOUR
//  - Reset (reset==0, async): state=IDLE, pndng_out=0, data_out=0, grant_o=0,
//    pkt_cnt=0, last=NUM_REQ-1 so requester 0 has top priority first.
//    A held packet is dropped; pop_o=0 while reset is low.
//  - FSM states: IDLE (no packet held) and HOLD (pndng_out=1).
//  - Selection, combinational: first r with pndng_i[r]=1 scanning last+1, last+2, ...
//    modulo NUM_REQ, wrapping past NUM_REQ-1 to 0.
//  - Load condition: (IDLE, or HOLD & popin) & |pndng_i.
//    pop_o[sel]=1 for exactly that cycle. It is combinational from state, pndng_i and popin.
//    At the edge: data_out<=data_i[sel], grant_o<=onehot(sel), last<=sel, state=HOLD.
//  - HOLD & popin & no pndng_i: at the edge pndng_out<=0, grant_o<=0, state=IDLE.
//    data_out keeps its value.
//  - HOLD & popin & pndng_i: back-to-back. The new packet loads on the same edge, and
//    pndng_out stays 1. Throughput is 1 packet/cycle.
//  - HOLD & !popin: data_out, grant_o and pndng_out are stable. pop_o=0.
//  - popin while pndng_out=0 is ignored, with no counter change.
//  - pkt_cnt increments by 1 on each edge with pndng_out & popin.
//    It wraps from 2^CNT_W-1 to 0.
//  - Latency: pndng_i rising in IDLE at cycle n gives pop_o in cycle n and
//    pndng_out=1 from cycle n+1.
//  - pndng_i may change any cycle. Only the value in the load cycle matters.
//    A requester that drops pndng_i before being served is skipped.
//  - Fairness: with all requesters pending, grants rotate 0,1,..,NUM_REQ-1,0,...
//    No requester waits more than NUM_REQ-1 grants.
// CONFIGURATION
//  PRIORITY_BDCST_EN defined: a pending requester whose head id field == bdcst is
//    eligible before all non-broadcast requesters.
//    Round-robin from last+1 applies within the broadcast set.
//    Round-robin applies among the rest only when no broadcast is pending.
//  Not defined: pure round-robin. The packet header is ignored.
// TESTING
//  1. Reset low mid-HOLD with pndng_out=1 -> outputs go to reset values immediately.
//     Then release reset with pndng_i=4'b1111 -> first grant_o=4'b0001.
//  2. pndng_i=4'b1111 held, popin=1 every cycle -> grant_o sequence 1,2,4,8,1.
//     pop_o is one-hot each cycle. pkt_cnt=5 after 5 consumes.
//  3. Only FIFO 2 pending, data_i[2]=40'h01_2345_6789 -> pop_o=4'b0100 in that cycle.
//     Next cycle data_out=40'h01_2345_6789 and pndng_out=1.
//     popin held 0 for 10 cycles -> data_out stable and no further pops.
//  4. Single packet, then popin=1 with no pndng_i -> pndng_out=0 and grant_o=0 next cycle.
//     popin=1 while idle -> pkt_cnt unchanged.
//  5. Load pkt_cnt to 16'hFFFF (force), then consume one packet -> pkt_cnt=16'h0000.
//  6. PRIORITY_BDCST_EN: last=0, FIFO1 id=8'h03, FIFO3 id=8'hFF, both pending ->
//     grant_o=4'b1000 first, then 4'b0010.
//     Without the macro the order is FIFO1 then FIFO3.

Source files
------------

// File: rtl/mesh_port_arbiter.sv
// Round-robin arbiter for one mesh-router output link with a single-packet output register.
// Define PRIORITY_BDCST_EN to serve pending broadcast packets ahead of all other requesters.
module mesh_port_arbiter #(
    parameter int              NUM_REQ = 4,
    parameter int              pckg_sz = 40,
    parameter int              ID_W    = 8,
    parameter logic [ID_W-1:0] bdcst   = {ID_W{1'b1}},
    parameter int              CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         pndng_i,
    input  logic [NUM_REQ*pckg_sz-1:0] data_i,
    output logic [NUM_REQ-1:0]         pop_o,
    output logic [pckg_sz-1:0]         data_out,
    output logic                       pndng_out,
    input  logic                       popin,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic [CNT_W-1:0]           pkt_cnt
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [IDX_W-1:0]   last;
    logic [IDX_W-1:0]   sel;
    logic               pick_valid;
    logic [NUM_REQ-1:0] sel_oh;
    logic               load;

    // Returns {found, index} of the first set bit scanning after+1, after+2, ... with wrap.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] mask,
                                               input logic [IDX_W-1:0]   after);
        logic [IDX_W:0] res;
        int             idx;
        res = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(after) + i) % NUM_REQ;
            if (!res[IDX_W] && mask[idx[IDX_W-1:0]]) begin
                res = {1'b1, idx[IDX_W-1:0]};
            end
        end
        return res;
    endfunction

`ifdef PRIORITY_BDCST_EN
    logic [NUM_REQ-1:0] is_bdcst;
    logic [IDX_W:0]     pick_b;
    logic [IDX_W:0]     pick_all;

    always_comb begin
        is_bdcst = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            is_bdcst[r] = pndng_i[r] &&
                          (data_i[r*pckg_sz + pckg_sz - ID_W +: ID_W] == bdcst);
        end
        pick_b     = rr_pick(is_bdcst, last);
        pick_all   = rr_pick(pndng_i, last);
        pick_valid = pick_all[IDX_W];
        sel        = pick_b[IDX_W] ? pick_b[IDX_W-1:0] : pick_all[IDX_W-1:0];
    end
`else
    logic [IDX_W:0] pick_all;

    always_comb begin
        pick_all   = rr_pick(pndng_i, last);
        pick_valid = pick_all[IDX_W];
        sel        = pick_all[IDX_W-1:0];
    end
`endif

    always_comb begin
        sel_oh      = '0;
        sel_oh[sel] = 1'b1;
    end

    // Load gating includes reset so no FIFO is popped while the arbiter is held in reset.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        pop_o      = '0;
        case (state)
            IDLE: load = reset && pick_valid;
            HOLD: begin
                load = reset && popin && pick_valid;
                if (popin && !pick_valid) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        if (load) begin
            next_state = HOLD;
            pop_o      = sel_oh;
        end
    end

    assign pndng_out = (state == HOLD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            data_out <= '0;
            grant_o  <= '0;
            last     <= IDX_W'(NUM_REQ - 1);
            pkt_cnt  <= '0;
        end else begin
            state <= next_state;
            if (load) begin
                data_out <= data_i[sel*pckg_sz +: pckg_sz];
                grant_o  <= sel_oh;
                last     <= sel;
            end else if (state == HOLD && popin) begin
                grant_o <= '0;
            end
            if (pndng_out && popin) begin
                pkt_cnt <= pkt_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mesh_port_arbiter.sv
// Directed self-checking bench for mesh_port_arbiter with hand-computed expectations.
module tb_mesh_port_arbiter;

    localparam int NUM_REQ = 4;
    localparam int PCKG_SZ = 40;
    localparam int CNT_W   = 16;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [NUM_REQ-1:0]         pndng_i;
    logic [NUM_REQ*PCKG_SZ-1:0] data_i;
    logic [NUM_REQ-1:0]         pop_o;
    logic [PCKG_SZ-1:0]         data_out;
    logic                       pndng_out;
    logic                       popin;
    logic [NUM_REQ-1:0]         grant_o;
    logic [CNT_W-1:0]           pkt_cnt;

    int checks   = 0;
    int failures = 0;

    mesh_port_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .pndng_i   (pndng_i),
        .data_i    (data_i),
        .pop_o     (pop_o),
        .data_out  (data_out),
        .pndng_out (pndng_out),
        .popin     (popin),
        .grant_o   (grant_o),
        .pkt_cnt   (pkt_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] pnd, input logic pop);
        pndng_i = pnd;
        popin   = pop;
        #1;
    endtask

    function automatic logic [PCKG_SZ-1:0] pkt(input int r);
        return {8'h20 + 8'(r), 32'hCAFE_0000 + 32'(r)};
    endfunction

    logic [NUM_REQ-1:0] exp_oh;
    logic [NUM_REQ-1:0] first_oh;
    logic [NUM_REQ-1:0] second_oh;
    logic [PCKG_SZ-1:0] held;
    int                 exp_r;

    initial begin
        reset   = 1'b0;
        pndng_i = '0;
        popin   = 1'b0;
        data_i  = '0;
        for (int r = 0; r < NUM_REQ; r++) data_i[r*PCKG_SZ +: PCKG_SZ] = pkt(r);

        // Reset state, with every FIFO requesting while reset is low
        applyStimulus(4'hF, 1'b0);
        checkOutput("rst_pop", pop_o, 4'h0);
        checkOutput("rst_pndng_out", pndng_out, 1'b0);
        checkOutput("rst_grant", grant_o, 4'h0);
        checkOutput("rst_cnt", pkt_cnt, 16'h0);
        checkOutput("rst_data", data_out, 40'h0);
        tick();
        tick();
        reset = 1'b1;

        // Test 1: hold a packet, then reset asynchronously mid-HOLD
        applyStimulus(4'b0100, 1'b0);
        checkOutput("t1_pop2", pop_o, 4'b0100);
        tick();
        checkOutput("t1_hold_pndng", pndng_out, 1'b1);
        checkOutput("t1_hold_grant", grant_o, 4'b0100);
        applyStimulus(4'hF, 1'b0);
        reset = 1'b0;
        #1;
        checkOutput("t1_async_pndng", pndng_out, 1'b0);
        checkOutput("t1_async_grant", grant_o, 4'h0);
        checkOutput("t1_async_data", data_out, 40'h0);
        checkOutput("t1_async_pop", pop_o, 4'h0);
        tick();
        reset = 1'b1;
        #1;
        checkOutput("t1_first_pop", pop_o, 4'b0001);
        tick();
        checkOutput("t1_first_grant", grant_o, 4'b0001);
        checkOutput("t1_first_data", data_out, pkt(0));

        // Test 2: all pending, back-to-back consumes rotate the grant
        for (int k = 0; k < 5; k++) begin
            exp_r  = (k + 1) % NUM_REQ;
            exp_oh = '0;
            exp_oh[exp_r] = 1'b1;
            applyStimulus(4'hF, 1'b1);
            checkOutput("t2_pop", pop_o, exp_oh);
            tick();
            checkOutput("t2_grant", grant_o, exp_oh);
            checkOutput("t2_data", data_out, pkt(exp_r));
            checkOutput("t2_cnt", pkt_cnt, 16'(k + 1));
        end

        // Test 4: drain with nothing pending, then popin while idle
        applyStimulus(4'h0, 1'b1);
        checkOutput("t4_pop", pop_o, 4'h0);
        tick();
        checkOutput("t4_pndng_out", pndng_out, 1'b0);
        checkOutput("t4_grant", grant_o, 4'h0);
        checkOutput("t4_data_kept", data_out, pkt(1));
        checkOutput("t4_cnt", pkt_cnt, 16'd6);
        tick();
        tick();
        checkOutput("t4_idle_cnt", pkt_cnt, 16'd6);

        // Test 3: single requester, downstream stalls for ten cycles
        data_i[2*PCKG_SZ +: PCKG_SZ] = 40'h01_2345_6789;
        applyStimulus(4'b0100, 1'b0);
        checkOutput("t3_pop", pop_o, 4'b0100);
        tick();
        checkOutput("t3_data", data_out, 40'h01_2345_6789);
        checkOutput("t3_pndng_out", pndng_out, 1'b1);
        checkOutput("t3_grant", grant_o, 4'b0100);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(4'b0100, 1'b0);
            checkOutput("t3_stall_pop", pop_o, 4'h0);
            tick();
            checkOutput("t3_stall_data", data_out, 40'h01_2345_6789);
        end
        checkOutput("t3_stall_pndng", pndng_out, 1'b1);
        checkOutput("t3_stall_cnt", pkt_cnt, 16'd6);
        applyStimulus(4'h0, 1'b1);
        tick();
        checkOutput("t3_drain_cnt", pkt_cnt, 16'd7);
        checkOutput("t3_drain_pndng", pndng_out, 1'b0);

        // Test 6: make last=0, then FIFO1 (plain id) and FIFO3 (broadcast id) compete
        applyStimulus(4'b0001, 1'b0);
        tick();
        applyStimulus(4'h0, 1'b1);
        tick();
        checkOutput("t6_setup_cnt", pkt_cnt, 16'd8);
        data_i[1*PCKG_SZ +: PCKG_SZ] = {8'h03, 32'h1111_1111};
        data_i[3*PCKG_SZ +: PCKG_SZ] = {8'hFF, 32'h3333_3333};
`ifdef PRIORITY_BDCST_EN
        first_oh  = 4'b1000;
        second_oh = 4'b0010;
`else
        first_oh  = 4'b0010;
        second_oh = 4'b1000;
`endif
        applyStimulus(4'b1010, 1'b0);
        checkOutput("t6_first_pop", pop_o, first_oh);
        tick();
        checkOutput("t6_first_grant", grant_o, first_oh);
        applyStimulus(second_oh, 1'b1);
        checkOutput("t6_second_pop", pop_o, second_oh);
        tick();
        checkOutput("t6_second_grant", grant_o, second_oh);
        held = (second_oh == 4'b1000) ? {8'hFF, 32'h3333_3333} : {8'h03, 32'h1111_1111};
        checkOutput("t6_second_data", data_out, held);
        checkOutput("t6_cnt", pkt_cnt, 16'd9);
        applyStimulus(4'h0, 1'b1);
        tick();
        checkOutput("t6_drain_cnt", pkt_cnt, 16'd10);

        // Test 5: run the counter up to its maximum and across the wrap
        applyStimulus(4'hF, 1'b1);
        tick();
        checkOutput("t5_start_cnt", pkt_cnt, 16'd10);
        for (int i = 0; i < 16'hFFFF - 10; i++) tick();
        checkOutput("t5_max_cnt", pkt_cnt, 16'hFFFF);
        checkOutput("t5_max_pndng", pndng_out, 1'b1);
        applyStimulus(4'h0, 1'b1);
        tick();
        checkOutput("t5_wrap_cnt", pkt_cnt, 16'h0000);
        checkOutput("t5_wrap_pndng", pndng_out, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
